fcs_append: RTL and testbench

FCS_APPEND -- requirements
Module: fcs_append

---
 rtl/eth_pkg.sv | 29 ++
 rtl/crc32_d8.sv | 21 ++
 rtl/fcs_append.sv | 142 ++++++++++++++
 tb/tb_fcs_append.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet TX/RX definitions: FSM state encoding, CRC-32 constants and
// the FCS byte selector. State StPad exists only when ETH_TX_PAD_EN is defined.
package eth_pkg;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam int unsigned ETH_MIN_PAYLOAD = 60;
    localparam int unsigned FCS_BYTES       = 4;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StPayload = 3'd1,
`ifdef ETH_TX_PAD_EN
        StPad     = 3'd2,
`endif
        StFcs     = 3'd3,
        StIfg     = 3'd4
    } state_t;

    // FCS byte idx (0 = first on the wire); a corrupt frame sends the raw register
    function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] idx,
                                            input logic corrupt);
        logic [31:0] v;
        v = corrupt ? crc : ~crc;
        v = v >> {idx, 3'b000};
        return v[7:0];
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide reflected CRC-32 next-state (LSB of data first). Purely combinational
// so the receive path can reuse it.
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);

    // Eight serial shift/xor steps unrolled into one cycle
    always_comb begin
        logic [31:0] c;
        c = crc_in ^ {24'h000000, data_in};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/fcs_append.sv
// Ethernet TX framer: streams payload from a FWFT FIFO, optionally pads to the
// minimum payload size (macro ETH_TX_PAD_EN), appends the CRC-32 FCS and
// enforces the inter-frame gap. An underrun sends a deliberately bad FCS.
module fcs_append
    import eth_pkg::*;
#(
    parameter int unsigned IFG_CYCLES = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] fifo_data,
    input  logic       fifo_eof,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    output logic [7:0] tx_data,
    output logic       tx_ctrl,
    output logic       tx_done,
    output logic       tx_underrun,
    output logic       busy
);

    state_t      state;
    logic [31:0] crc;
    logic [10:0] count;
    logic        corrupt;
    logic [1:0]  fcs_idx;
    logic [15:0] ifg_cnt;

    logic [31:0] crc_base;
    logic [7:0]  crc_byte;
    logic [31:0] crc_next;
    logic [10:0] count_next;
    state_t      eof_state;

    // Pop the head byte whenever a payload-consuming state sees data
    always_comb begin
        fifo_rd_en = 1'b0;
        if (!reset && !fifo_empty && (state == StIdle || state == StPayload)) begin
            fifo_rd_en = 1'b1;
        end
    end

    // CRC and counter inputs; a pop in IDLE always starts from the preset value
    always_comb begin
        crc_base = (state == StIdle) ? CRC32_INIT : crc;
        crc_byte = (state == StIdle || state == StPayload) ? fifo_data : 8'h00;
        if (state == StIdle) begin
            count_next = 11'd1;
        end else if (count == 11'h7FF) begin
            count_next = count;
        end else begin
            count_next = count + 11'd1;
        end
`ifdef ETH_TX_PAD_EN
        eof_state = (count_next < 11'(ETH_MIN_PAYLOAD)) ? StPad : StFcs;
`else
        eof_state = StFcs;
`endif
    end

    crc32_d8 u_crc (
        .crc_in  (crc_base),
        .data_in (crc_byte),
        .crc_out (crc_next)
    );

    assign busy = (state != StIdle);

    // Framing FSM with registered transmit outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= StIdle;
            crc         <= CRC32_INIT;
            count       <= '0;
            corrupt     <= 1'b0;
            fcs_idx     <= '0;
            ifg_cnt     <= '0;
            tx_data     <= 8'h00;
            tx_ctrl     <= 1'b0;
            tx_done     <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            tx_data     <= 8'h00;
            tx_ctrl     <= 1'b0;
            tx_done     <= 1'b0;
            tx_underrun <= 1'b0;
            unique case (state)
                StIdle: begin
                    crc     <= CRC32_INIT;
                    count   <= '0;
                    corrupt <= 1'b0;
                    fcs_idx <= '0;
                    ifg_cnt <= '0;
                    if (!fifo_empty) begin
                        tx_data <= fifo_data;
                        tx_ctrl <= 1'b1;
                        crc     <= crc_next;
                        count   <= count_next;
                        state   <= fifo_eof ? eof_state : StPayload;
                    end
                end
                StPayload: begin
                    if (!fifo_empty) begin
                        tx_data <= fifo_data;
                        tx_ctrl <= 1'b1;
                        crc     <= crc_next;
                        count   <= count_next;
                        if (fifo_eof) state <= eof_state;
                    end else begin
                        // Starved mid-frame: finish with a poisoned FCS
                        tx_underrun <= 1'b1;
                        corrupt     <= 1'b1;
                        state       <= StFcs;
                    end
                end
`ifdef ETH_TX_PAD_EN
                StPad: begin
                    tx_ctrl <= 1'b1;
                    crc     <= crc_next;
                    count   <= count_next;
                    if (count_next >= 11'(ETH_MIN_PAYLOAD)) state <= StFcs;
                end
`endif
                StFcs: begin
                    tx_data <= fcs_byte(crc, fcs_idx, corrupt);
                    tx_ctrl <= 1'b1;
                    fcs_idx <= fcs_idx + 2'd1;
                    if (fcs_idx == 2'(FCS_BYTES - 1)) begin
                        tx_done <= 1'b1;
                        state   <= StIfg;
                    end
                end
                StIfg: begin
                    ifg_cnt <= ifg_cnt + 16'd1;
                    if (ifg_cnt == 16'(IFG_CYCLES - 1)) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fcs_append.sv
// Bench for fcs_append: a queue-based FWFT FIFO feeds random frames; expected
// wire bytes come from a table-driven CRC-32 model of the framing rules.
`timescale 1ns/1ps
module tb_fcs_append;

    localparam int unsigned IFG = 12;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] fifo_data;
    logic       fifo_eof;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] tx_data;
    logic       tx_ctrl;
    logic       tx_done;
    logic       tx_underrun;
    logic       busy;

    fcs_append #(.IFG_CYCLES(IFG)) dut (
        .clk         (clk),
        .reset       (reset),
        .fifo_data   (fifo_data),
        .fifo_eof    (fifo_eof),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .tx_data     (tx_data),
        .tx_ctrl     (tx_ctrl),
        .tx_done     (tx_done),
        .tx_underrun (tx_underrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    logic [8:0]  fifo_q [$];
    logic [7:0]  pl_q [$];
    logic [7:0]  cap_q [$];
    logic [7:0]  exp_q [$];
    int          gaps [$];
    logic [31:0] crc_tab [256];
    int          done_cnt, und_cnt, done_at, gap_run;
    bit          seen_high;
    logic        pop_now;
    logic [8:0]  popped;

    task automatic refresh();
        if (fifo_q.size() == 0) begin
            fifo_empty = 1'b1;
            fifo_data  = 8'h00;
            fifo_eof   = 1'b0;
        end else begin
            fifo_empty = 1'b0;
            {fifo_eof, fifo_data} = fifo_q[0];
        end
    endtask

    // FIFO pops one entry per cycle in which the DUT asserts fifo_rd_en
    always @(posedge clk) begin
        pop_now = fifo_rd_en;
        #1;
        if (pop_now && fifo_q.size() > 0) begin
            popped = fifo_q.pop_front();
            refresh();
        end
    end

    // Wire monitor: capture bytes, pulses and low-tx_ctrl gap lengths
    always @(negedge clk) begin
        if (!reset) begin
            if (tx_ctrl) begin
                if (seen_high && gap_run > 0) gaps.push_back(gap_run);
                gap_run   = 0;
                seen_high = 1'b1;
                cap_q.push_back(tx_data);
            end else begin
                gap_run++;
            end
            if (tx_done) begin
                done_cnt++;
                done_at = tx_ctrl ? cap_q.size() - 1 : -2;
            end
            if (tx_underrun) und_cnt++;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        cap_q.delete();
        exp_q.delete();
        gaps.delete();
        done_cnt  = 0;
        und_cnt   = 0;
        done_at   = -1;
        gap_run   = 0;
        seen_high = 1'b0;
    endtask

    // Queue a payload into the FIFO; random bytes unless pl_q is pre-filled
    task automatic push_payload(input int len, input bit rnd, input bit eof);
        if (rnd) begin
            pl_q.delete();
            for (int i = 0; i < len; i++) pl_q.push_back(8'($urandom_range(0, 255)));
        end
        for (int i = 0; i < pl_q.size(); i++) begin
            fifo_q.push_back({(eof && i == pl_q.size() - 1), pl_q[i]});
        end
        refresh();
    endtask

    // Reference frame for pl_q, appended to exp_q
    task automatic build_exp(input bit corrupt);
        logic [7:0]  fr [$];
        logic [31:0] c;
        fr = pl_q;
`ifdef ETH_TX_PAD_EN
        if (!corrupt) while (fr.size() < 60) fr.push_back(8'h00);
`endif
        c = 32'hFFFFFFFF;
        foreach (fr[i]) c = crc_tab[c[7:0] ^ fr[i]] ^ (c >> 8);
        if (!corrupt) c = ~c;
        for (int i = 0; i < 4; i++) begin
            fr.push_back(c[7:0]);
            c = c >> 8;
        end
        foreach (fr[i]) exp_q.push_back(fr[i]);
    endtask

    function automatic int first_diff();
        int n;
        n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (cap_q[i] !== exp_q[i]) return i;
        if (cap_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    // Wait for n tx_done pulses and the DUT back in IDLE
    task automatic wait_frames(input int n, input int budget, output bit ok);
        int k;
        k = 0;
        while (!(done_cnt >= n && !busy) && k < budget) begin
            step();
            k++;
        end
        ok = (k < budget);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        fifo_q.push_back(9'h0AB);
        refresh();
        step();
        vectors++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
        vectors++; if (tx_ctrl !== 1'b0) begin errors++; $display("FAIL rst_tx_ctrl: got %b want 0", tx_ctrl); end
        vectors++; if (tx_done !== 1'b0) begin errors++; $display("FAIL rst_tx_done: got %b want 0", tx_done); end
        vectors++; if (tx_underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun: got %b want 0", tx_underrun); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        vectors++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en: got %b want 0", fifo_rd_en); end
        fifo_q.delete();
        refresh();
        step();
        reset = 1'b0;
        repeat (3) step();
        vectors++; if (busy !== 1'b0 || tx_ctrl !== 1'b0) begin
            errors++; $display("FAIL idle_empty: got busy=%b ctrl=%b want 0/0", busy, tx_ctrl);
        end
    endtask

    task automatic test_known_vector();
        bit ok;
        int d;
        clear_mon();
        pl_q.delete();
        for (int i = 0; i < 9; i++) pl_q.push_back(8'h31 + 8'(i));
        push_payload(9, 1'b0, 1'b1);
        wait_frames(1, 300, ok);
        vectors++; if (ok !== 1'b1) begin errors++; $display("FAIL known_timeout: got done=%0d want 1", done_cnt); end
        build_exp(1'b0);
        d = first_diff();
        vectors++; if (d != -1) begin
            errors++; $display("FAIL known_frame: got len %0d diff at %0d, want len %0d", cap_q.size(), d, exp_q.size());
        end
`ifdef ETH_TX_PAD_EN
        vectors++; if (cap_q.size() != 64) begin errors++; $display("FAIL known_len: got %0d want 64", cap_q.size()); end
`else
        vectors++; if (cap_q.size() != 13) begin errors++; $display("FAIL known_len: got %0d want 13", cap_q.size()); end
        if (cap_q.size() == 13) begin
            vectors++;
            if ({cap_q[9], cap_q[10], cap_q[11], cap_q[12]} !== 32'h2639F4CB) begin
                errors++;
                $display("FAIL known_fcs: got %h%h%h%h want 2639F4CB", cap_q[9], cap_q[10], cap_q[11], cap_q[12]);
            end
        end
`endif
        vectors++; if (done_at != cap_q.size() - 1) begin
            errors++; $display("FAIL known_done_pos: got %0d want %0d", done_at, cap_q.size() - 1);
        end
        vectors++; if (gaps.size() != 0) begin errors++; $display("FAIL known_contig: got %0d gaps want 0", gaps.size()); end
    endtask

    task automatic test_random_frames();
        int lens [8];
        bit ok;
        int d;
        lens = '{1, 2, 59, 60, 61, 0, 0, 0};
        for (int f = 5; f < 8; f++) lens[f] = $urandom_range(3, 150);
        for (int f = 0; f < 8; f++) begin
            clear_mon();
            push_payload(lens[f], 1'b1, 1'b1);
            wait_frames(1, 400, ok);
            vectors++; if (ok !== 1'b1) begin errors++; $display("FAIL rnd_timeout_%0d: got done=%0d want 1", f, done_cnt); end
            build_exp(1'b0);
            d = first_diff();
            vectors++; if (d != -1) begin
                errors++;
                $display("FAIL rnd_frame_%0d(len %0d): got len %0d diff at %0d, want len %0d",
                         f, lens[f], cap_q.size(), d, exp_q.size());
            end
            vectors++; if (done_at != cap_q.size() - 1 || und_cnt != 0) begin
                errors++; $display("FAIL rnd_flags_%0d: got done_at=%0d und=%0d want %0d/0",
                                   f, done_at, und_cnt, cap_q.size() - 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pa [$];
        logic [7:0] pb [$];
        bit ok;
        int d, g0;
        clear_mon();
        push_payload(64, 1'b1, 1'b1);
        pa = pl_q;
        push_payload(64, 1'b1, 1'b1);
        pb = pl_q;
        wait_frames(2, 800, ok);
        vectors++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_timeout: got done=%0d want 2", done_cnt); end
        pl_q = pa;
        build_exp(1'b0);
        pl_q = pb;
        build_exp(1'b0);
        d = first_diff();
        vectors++; if (d != -1) begin
            errors++; $display("FAIL b2b_frames: got len %0d diff at %0d, want len %0d", cap_q.size(), d, exp_q.size());
        end
        g0 = (gaps.size() > 0) ? gaps[0] : -1;
        vectors++; if (gaps.size() != 1 || g0 != IFG) begin
            errors++; $display("FAIL b2b_ifg: got %0d gaps first %0d, want 1 gap of %0d", gaps.size(), g0, IFG);
        end
    endtask

    task automatic test_underrun();
        bit ok;
        int d;
        clear_mon();
        push_payload(20, 1'b1, 1'b0);
        wait_frames(1, 300, ok);
        vectors++; if (ok !== 1'b1) begin errors++; $display("FAIL und_timeout: got done=%0d want 1", done_cnt); end
        vectors++; if (und_cnt != 1) begin errors++; $display("FAIL und_pulse: got %0d want 1", und_cnt); end
        build_exp(1'b1);
        d = first_diff();
        vectors++; if (d != -1) begin
            errors++; $display("FAIL und_frame: got len %0d diff at %0d, want len %0d", cap_q.size(), d, exp_q.size());
        end
        vectors++; if (fifo_empty !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL und_idle: got empty=%b busy=%b want 1/0", fifo_empty, busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int k, d;
        clear_mon();
        push_payload(100, 1'b1, 1'b1);
        k = 0;
        while (cap_q.size() < 30 && k < 200) begin
            step();
            k++;
        end
        vectors++; if (cap_q.size() < 30) begin errors++; $display("FAIL mid_start: got %0d bytes want 30", cap_q.size()); end
        reset = 1'b1;
        #1;
        vectors++; if (tx_ctrl !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00) begin
            errors++; $display("FAIL mid_reset: got ctrl=%b busy=%b data=%h want 0/0/00", tx_ctrl, busy, tx_data);
        end
        step();
        vectors++; if (tx_ctrl !== 1'b0 || fifo_rd_en !== 1'b0) begin
            errors++; $display("FAIL mid_hold: got ctrl=%b rd_en=%b want 0/0", tx_ctrl, fifo_rd_en);
        end
        fifo_q.delete();
        refresh();
        step();
        reset = 1'b0;
        step();
        clear_mon();
        push_payload(37, 1'b1, 1'b1);
        wait_frames(1, 400, ok);
        vectors++; if (ok !== 1'b1) begin errors++; $display("FAIL post_timeout: got done=%0d want 1", done_cnt); end
        build_exp(1'b0);
        d = first_diff();
        vectors++; if (d != -1) begin
            errors++; $display("FAIL post_frame: got len %0d diff at %0d, want len %0d", cap_q.size(), d, exp_q.size());
        end
    endtask

    initial begin
        for (int n = 0; n < 256; n++) begin
            logic [31:0] c;
            c = 32'(n);
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[n] = c;
        end
        reset = 1'b1;
        refresh();
        clear_mon();
        test_reset();
        test_known_vector();
        test_random_frames();
        test_back_to_back();
        test_underrun();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
